pwm_generator: RTL and testbench

PWM_GENERATOR -- requirements
Module: pwm_generator

---
 rtl/pwm_generator_pkg.sv | 9 +
 rtl/pwm_prescaler.sv | 20 ++
 rtl/pwm_generator.sv | 41 ++++
 tb/tb_pwm_generator.sv | 125 ++++++++++++
 4 files changed

// File: rtl/pwm_generator_pkg.sv
// pwm_generator_pkg: shared PWM widths, period length and prescaler sizing helper
package pwm_generator_pkg;
  localparam int PWM_WIDTH = 8;
  localparam int PWM_PERIOD_TICKS = 255;
  localparam logic [PWM_WIDTH-1:0] CNT_MAX = PWM_WIDTH'(PWM_PERIOD_TICKS - 1);
  function automatic int psc_width(input int prescale);
    return prescale > 1 ? $clog2(prescale) : 1;
  endfunction
endpackage

// File: rtl/pwm_prescaler.sv
// pwm_prescaler: emits a one-cycle tick every PRESCALE clk cycles while en is high
module pwm_prescaler
  import pwm_generator_pkg::*;
#(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);
  localparam int W = psc_width(PRESCALE);
  localparam logic [W-1:0] LAST = W'(PRESCALE - 1);
  logic [W-1:0] psc;
  assign tick = en && psc == LAST;
  always_ff @(posedge clk) begin
    if (rst || !en) psc <= '0;
    else psc <= tick ? '0 : psc + W'(1);
  end
endmodule

// File: rtl/pwm_generator.sv
// pwm_generator: 255-tick PWM with period-boundary duty shadowing and fully registered outputs
module pwm_generator
  import pwm_generator_pkg::*;
#(
  parameter int PRESCALE = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [PWM_WIDTH-1:0] pwm_val,
  output logic                 pwm_out,
  output logic                 period_start
);
  logic en_q, tick, start, wrap;
  logic [PWM_WIDTH-1:0] cnt, duty_sh;
  assign start = en && !en_q;
  assign wrap = tick && cnt == CNT_MAX;
  // The prescaler stays cleared on the enabling edge so the fresh period begins at psc=0.
  pwm_prescaler #(.PRESCALE(PRESCALE)) u_psc (
    .clk (clk),
    .rst (rst),
    .en  (en && en_q),
    .tick(tick)
  );
  // Gating with en_q keeps the stale duty from leaking out on the enabling edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      en_q <= 1'b0;
      cnt <= '0;
      duty_sh <= '0;
      pwm_out <= 1'b0;
      period_start <= 1'b0;
    end else begin
      en_q <= en;
      period_start <= start || wrap;
      pwm_out <= en && en_q && (cnt < duty_sh);
      cnt <= (!en || start || wrap) ? '0 : tick ? cnt + 1'b1 : cnt;
      if (start || wrap) duty_sh <= pwm_val;
    end
  end
endmodule

// File: tb/tb_pwm_generator.sv
// tb_pwm_generator: directed checks of duty, period, shadowing, enable and reset behaviour
module tb_pwm_generator;
  logic clk = 1'b0, rst = 1'b1, en1 = 1'b0, en4 = 1'b0;
  logic [7:0] val1 = '0, val4 = '0;
  logic out1, ps1, out4, ps4;
  int tests = 0, fails = 0;
  int hi, np, fp, fl, acc;
  always #5 clk = ~clk;
  pwm_generator #(.PRESCALE(1)) u1 (
    .clk(clk), .rst(rst), .en(en1), .pwm_val(val1), .pwm_out(out1), .period_start(ps1)
  );
  pwm_generator #(.PRESCALE(4)) u4 (
    .clk(clk), .rst(rst), .en(en4), .pwm_val(val4), .pwm_out(out4), .period_start(ps4)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic run(input bit sel, input int n, output int h, output int p, output int f_ps, output int f_lo);
    logic o, s;
    h = 0; p = 0; f_ps = -1; f_lo = -1;
    for (int k = 1; k <= n; k++) begin
      step();
      o = sel ? out4 : out1;
      s = sel ? ps4 : ps1;
      if (o) h++;
      else if (f_lo < 0) f_lo = k;
      if (s) begin
        p++;
        if (f_ps < 0) f_ps = k;
      end
    end
  endtask
  task automatic restart1(input logic [7:0] v);
    en1 = 1'b0;
    step();
    val1 = v;
    en1 = 1'b1;
    step();
    check("restart_ps", ps1, 1);
  endtask
  initial begin
    step();
    step();
    check("rst_out1", out1, 0);
    check("rst_ps1", ps1, 0);
    check("rst_out4", out4, 0);
    check("rst_ps4", ps4, 0);
    rst = 1'b0;
    val1 = 8'd0;
    en1 = 1'b1;
    step();
    check("zero_start_ps", ps1, 1);
    check("zero_start_out", out1, 0);
    run(0, 510, hi, np, fp, fl);
    check("zero_hi", hi, 0);
    check("zero_np", np, 2);
    check("zero_fp", fp, 255);
    restart1(8'd255);
    run(0, 255, hi, np, fp, fl);
    check("full_hi", hi, 255);
    check("full_np", np, 1);
    run(0, 255, hi, np, fp, fl);
    check("full_hi2", hi, 255);
    restart1(8'd128);
    run(0, 255, hi, np, fp, fl);
    check("half_hi", hi, 128);
    check("half_fl", fl, 129);
    check("half_fp", fp, 255);
    restart1(8'd64);
    run(0, 100, hi, np, fp, fl);
    acc = hi;
    val1 = 8'd192;
    run(0, 155, hi, np, fp, fl);
    check("shadow_cur", acc + hi, 64);
    run(0, 255, hi, np, fp, fl);
    check("shadow_next", hi, 192);
    restart1(8'd128);
    run(0, 30, hi, np, fp, fl);
    check("en_pre_out", out1, 1);
    en1 = 1'b0;
    step();
    check("en_off_out", out1, 0);
    check("en_off_ps", ps1, 0);
    en1 = 1'b1;
    step();
    check("en_on_ps", ps1, 1);
    check("en_on_out", out1, 0);
    run(0, 255, hi, np, fp, fl);
    check("en_hi", hi, 128);
    check("en_fl", fl, 129);
    restart1(8'd77);
    run(0, 50, hi, np, fp, fl);
    rst = 1'b1;
    step();
    check("mrst_out", out1, 0);
    check("mrst_ps", ps1, 0);
    check("mrst_duty", u1.duty_sh, 0);
    rst = 1'b0;
    val1 = 8'd20;
    step();
    check("mrst_start_ps", ps1, 1);
    run(0, 255, hi, np, fp, fl);
    check("mrst_hi", hi, 20);
    check("mrst_fl", fl, 21);
    val4 = 8'd10;
    en4 = 1'b1;
    step();
    check("p4_start_ps", ps4, 1);
    run(1, 1020, hi, np, fp, fl);
    check("p4_hi", hi, 40);
    check("p4_fl", fl, 41);
    check("p4_np", np, 1);
    check("p4_fp", fp, 1020);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
